// File: rtl/rename_pkg.sv
// Shared types and sizes for the 2-wide register rename stage.
package rename_pkg;

    localparam int AREG_NUM       = 32;
    localparam int AREG_WIDTH     = 5;
    localparam int PREG_WIDTH     = 6;
    localparam int FREE_CNT_WIDTH = 7;

    typedef logic [AREG_WIDTH-1:0] areg_t;
    typedef logic [PREG_WIDTH-1:0] preg_t;

    typedef struct packed {
        logic  valid;
        areg_t lrs1;
        areg_t lrs2;
        areg_t lrd;
        logic  wen;
    } rename_slot_t;

    typedef struct packed {
        logic  valid;
        preg_t prs1;
        preg_t prs2;
        preg_t prd;
        preg_t old_prd;
    } renamed_slot_t;

    // x0 is hard-wired, so a write to it never consumes a physical register.
    function automatic logic is_alloc(input rename_slot_t s);
        return s.valid && s.wen && (s.lrd != '0);
    endfunction

endpackage

// File: rtl/rename_map_table_if.sv
// Decode, freelist, dispatch, commit and flush signals of the rename stage.
interface rename_map_table_if;
    import rename_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic                      in0_valid, in1_valid;
    areg_t                     in0_lrs1, in0_lrs2, in0_lrd;
    areg_t                     in1_lrs1, in1_lrs2, in1_lrd;
    logic                      in0_wen, in1_wen;
    logic [FREE_CNT_WIDTH-1:0] fl_free_cnt;
    logic                      fl_rd_en0, fl_rd_en1;
    preg_t                     fl_rd_data0, fl_rd_data1;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out0_valid, out1_valid;
    preg_t                     out0_prs1, out0_prs2, out0_prd, out0_old_prd;
    preg_t                     out1_prs1, out1_prs2, out1_prd, out1_old_prd;
    logic                      cmt0_valid, cmt1_valid;
    areg_t                     cmt0_lrd, cmt1_lrd;
    preg_t                     cmt0_prd, cmt1_prd;
    logic                      flush;

    modport master (
        output in_valid, in0_valid, in1_valid, in0_lrs1, in0_lrs2, in0_lrd, in0_wen,
               in1_lrs1, in1_lrs2, in1_lrd, in1_wen, fl_free_cnt, fl_rd_data0, fl_rd_data1,
               out_ready, cmt0_valid, cmt1_valid, cmt0_lrd, cmt1_lrd, cmt0_prd, cmt1_prd, flush,
        input  in_ready, fl_rd_en0, fl_rd_en1, out_valid, out0_valid, out1_valid,
               out0_prs1, out0_prs2, out0_prd, out0_old_prd,
               out1_prs1, out1_prs2, out1_prd, out1_old_prd
    );

    modport slave (
        input  in_valid, in0_valid, in1_valid, in0_lrs1, in0_lrs2, in0_lrd, in0_wen,
               in1_lrs1, in1_lrs2, in1_lrd, in1_wen, fl_free_cnt, fl_rd_data0, fl_rd_data1,
               out_ready, cmt0_valid, cmt1_valid, cmt0_lrd, cmt1_lrd, cmt0_prd, cmt1_prd, flush,
        output in_ready, fl_rd_en0, fl_rd_en1, out_valid, out0_valid, out1_valid,
               out0_prs1, out0_prs2, out0_prd, out0_old_prd,
               out1_prs1, out1_prs2, out1_prd, out1_old_prd
    );

endinterface

// File: rtl/rat_bank.sv
// One logical->physical map table: 4 comb read ports, 2 write ports (port 1 wins), bulk load.
module rat_bank
    import rename_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  areg_t      rd_addr [4],
    output preg_t      rd_data [4],
    input  logic [1:0] wr_en,
    input  areg_t      wr_addr [2],
    input  preg_t      wr_data [2],
    input  logic       load_en,
    input  preg_t      load_data [AREG_NUM],
    output preg_t      contents [AREG_NUM],
    output preg_t      contents_next [AREG_NUM]
);

    preg_t mem      [AREG_NUM];
    preg_t mem_next [AREG_NUM];

    // NOTE: every variable driven here gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_next = mem;
        if (wr_en[0]) mem_next[wr_addr[0]] = wr_data[0];
        if (wr_en[1]) mem_next[wr_addr[1]] = wr_data[1];
    end

    // NOTE: the table is reset entry by entry because identity mapping is architectural state, not a don't-care.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < AREG_NUM; i++) mem[i] <= PREG_WIDTH'(i);
        end else begin
            // NOTE: non-blocking assignment so all entries update together from the pre-edge values.
            for (int i = 0; i < AREG_NUM; i++) mem[i] <= load_en ? load_data[i] : mem_next[i];
        end
    end

    always_comb begin
        for (int p = 0; p < 4; p++) rd_data[p] = mem[rd_addr[p]];
    end

    assign contents      = mem;
    assign contents_next = mem_next;

endmodule

// File: rtl/rename_map_table.sv
// 2-wide register alias table: renames a decode group using freelist pops, keeps an arch copy for flush.
module rename_map_table
    import rename_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    rename_map_table_if.slave    bus
);

    rename_slot_t  slot [2];
    renamed_slot_t res  [2];
    renamed_slot_t out_q [2];
    logic          out_valid_q;
    logic [1:0]    alloc;
    logic [1:0]    n_alloc;
    logic          fire;
    preg_t         prd0, prd1;

    preg_t spec_rd [4];
    preg_t spec_tbl [AREG_NUM];
    preg_t arch_tbl [AREG_NUM];
    preg_t arch_next [AREG_NUM];
    preg_t unused_spec_next [AREG_NUM];
    preg_t unused_arch_rd [4];

    assign slot[0] = {bus.in0_valid, bus.in0_lrs1, bus.in0_lrs2, bus.in0_lrd, bus.in0_wen};
    assign slot[1] = {bus.in1_valid, bus.in1_lrs1, bus.in1_lrs2, bus.in1_lrd, bus.in1_wen};

    assign alloc[0] = is_alloc(slot[0]);
    assign alloc[1] = is_alloc(slot[1]);
    assign n_alloc  = {1'b0, alloc[0]} + {1'b0, alloc[1]};

    // A group is accepted only whole: enough free registers, a free output stage, and no redirect.
    assign bus.in_ready  = !reset && !bus.flush && (!out_valid_q || bus.out_ready)
                           && (bus.fl_free_cnt >= FREE_CNT_WIDTH'(n_alloc));
    assign fire          = bus.in_valid && bus.in_ready;
    assign bus.fl_rd_en0 = fire && (n_alloc != 2'd0);
    assign bus.fl_rd_en1 = fire && (n_alloc == 2'd2);

    // The first allocating slot always takes pop 0, whichever slot that is.
    assign prd0 = alloc[0] ? bus.fl_rd_data0 : '0;
    assign prd1 = alloc[1] ? (alloc[0] ? bus.fl_rd_data1 : bus.fl_rd_data0) : '0;

    always_comb begin
        res[0] = '0;
        res[1] = '0;
        if (slot[0].valid) begin
            res[0].valid   = 1'b1;
            res[0].prs1    = (slot[0].lrs1 == '0) ? '0 : spec_rd[0];
            res[0].prs2    = (slot[0].lrs2 == '0) ? '0 : spec_rd[1];
            res[0].prd     = prd0;
            res[0].old_prd = alloc[0] ? spec_tbl[slot[0].lrd] : '0;
        end
        if (slot[1].valid) begin
            res[1].valid   = 1'b1;
            res[1].prs1    = (slot[1].lrs1 == '0) ? '0
                           : (alloc[0] && slot[1].lrs1 == slot[0].lrd) ? prd0 : spec_rd[2];
            res[1].prs2    = (slot[1].lrs2 == '0) ? '0
                           : (alloc[0] && slot[1].lrs2 == slot[0].lrd) ? prd0 : spec_rd[3];
            res[1].prd     = prd1;
            res[1].old_prd = !alloc[1] ? '0
                           : (alloc[0] && slot[1].lrd == slot[0].lrd) ? prd0 : spec_tbl[slot[1].lrd];
        end
    end

    // Speculative table; flush reloads it from the arch table including this cycle's commits.
    rat_bank u_spec (
        .clock         (clock),
        .reset         (reset),
        .rd_addr       ('{slot[0].lrs1, slot[0].lrs2, slot[1].lrs1, slot[1].lrs2}),
        .rd_data       (spec_rd),
        .wr_en         ({fire && alloc[1], fire && alloc[0]}),
        .wr_addr       ('{slot[0].lrd, slot[1].lrd}),
        .wr_data       ('{prd0, prd1}),
        .load_en       (bus.flush),
        .load_data     (arch_next),
        .contents      (spec_tbl),
        .contents_next (unused_spec_next)
    );

    rat_bank u_arch (
        .clock         (clock),
        .reset         (reset),
        .rd_addr       ('{default: '0}),
        .rd_data       (unused_arch_rd),
        .wr_en         ({bus.cmt1_valid && bus.cmt1_lrd != '0, bus.cmt0_valid && bus.cmt0_lrd != '0}),
        .wr_addr       ('{bus.cmt0_lrd, bus.cmt1_lrd}),
        .wr_data       ('{bus.cmt0_prd, bus.cmt1_prd}),
        .load_en       (1'b0),
        .load_data     (arch_tbl),
        .contents      (arch_tbl),
        .contents_next (arch_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q[0]    <= '0;
            out_q[1]    <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            out_q[0]    <= res[0];
            out_q[1]    <= res[1];
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out0_valid   = out_q[0].valid;
    assign bus.out0_prs1    = out_q[0].prs1;
    assign bus.out0_prs2    = out_q[0].prs2;
    assign bus.out0_prd     = out_q[0].prd;
    assign bus.out0_old_prd = out_q[0].old_prd;
    assign bus.out1_valid   = out_q[1].valid;
    assign bus.out1_prs1    = out_q[1].prs1;
    assign bus.out1_prs2    = out_q[1].prs2;
    assign bus.out1_prd     = out_q[1].prd;
    assign bus.out1_old_prd = out_q[1].old_prd;

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: hand-computed expected mappings per scenario.
module tb_rename_map_table;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total  = 0;
    int   passed = 0;

    rename_map_table_if bus();

    rename_map_table dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int s, input bit v, input int lrs1, input int lrs2, input int lrd, input bit wen);
        if (s == 0) begin
            bus.in0_valid = v; bus.in0_lrs1 = 5'(lrs1); bus.in0_lrs2 = 5'(lrs2);
            bus.in0_lrd = 5'(lrd); bus.in0_wen = wen;
        end else begin
            bus.in1_valid = v; bus.in1_lrs1 = 5'(lrs1); bus.in1_lrs2 = 5'(lrs2);
            bus.in1_lrd = 5'(lrd); bus.in1_wen = wen;
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        set_slot(0, 0, 0, 0, 0, 0);
        set_slot(1, 0, 0, 0, 0, 0);
        bus.cmt0_valid = 1'b0; bus.cmt0_lrd = '0; bus.cmt0_prd = '0;
        bus.cmt1_valid = 1'b0; bus.cmt1_lrd = '0; bus.cmt1_prd = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        bus.fl_free_cnt = 7'd64;
        bus.fl_rd_data0 = '0;
        bus.fl_rd_data1 = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.in_valid = 1'b1;
        set_slot(0, 1, 2, 3, 1, 1);
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %0d exp 0", bus.in_ready); else passed++;
        total++; if (bus.fl_rd_en0 !== 1'b0) $display("FAIL reset_fl_rd_en0 got %0d exp 0", bus.fl_rd_en0); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0d exp 0", bus.out_valid); else passed++;
        total++; if (bus.out0_prd !== 6'd0) $display("FAIL reset_out0_prd got %0d exp 0", bus.out0_prd); else passed++;
        idle();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_group();
        bus.in_valid = 1'b1;
        set_slot(0, 1, 2, 3, 1, 1);
        set_slot(1, 1, 1, 5, 4, 1);
        bus.fl_rd_data0 = 6'd32; bus.fl_rd_data1 = 6'd33;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_in_ready got %0d exp 1", bus.in_ready); else passed++;
        total++; if ({bus.fl_rd_en0, bus.fl_rd_en1} !== 2'b11) $display("FAIL basic_pops got %b exp 11", {bus.fl_rd_en0, bus.fl_rd_en1}); else passed++;
        tick();
        idle();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_out_valid got %0d exp 1", bus.out_valid); else passed++;
        total++; if ({bus.out0_prs1, bus.out0_prs2, bus.out0_prd, bus.out0_old_prd} !== {6'd2, 6'd3, 6'd32, 6'd1})
            $display("FAIL basic_out0 got %0d/%0d/%0d/%0d exp 2/3/32/1", bus.out0_prs1, bus.out0_prs2, bus.out0_prd, bus.out0_old_prd); else passed++;
        total++; if ({bus.out1_prs1, bus.out1_prs2, bus.out1_prd, bus.out1_old_prd} !== {6'd32, 6'd5, 6'd33, 6'd4})
            $display("FAIL basic_out1 got %0d/%0d/%0d/%0d exp 32/5/33/4", bus.out1_prs1, bus.out1_prs2, bus.out1_prd, bus.out1_old_prd); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drain got %0d exp 0", bus.out_valid); else passed++;
    endtask

    task automatic test_same_lrd();
        bus.in_valid = 1'b1;
        set_slot(0, 1, 0, 0, 7, 1);
        set_slot(1, 1, 0, 0, 7, 1);
        bus.fl_rd_data0 = 6'd40; bus.fl_rd_data1 = 6'd41;
        tick();
        total++; if (bus.out0_old_prd !== 6'd7) $display("FAIL same_out0_old got %0d exp 7", bus.out0_old_prd); else passed++;
        total++; if ({bus.out1_prd, bus.out1_old_prd} !== {6'd41, 6'd40}) $display("FAIL same_out1 got %0d/%0d exp 41/40", bus.out1_prd, bus.out1_old_prd); else passed++;
        idle();
        bus.in_valid = 1'b1;
        set_slot(0, 1, 7, 0, 0, 0);
        #1;
        total++; if (bus.fl_rd_en0 !== 1'b0) $display("FAIL same_reader_pop got %0d exp 0", bus.fl_rd_en0); else passed++;
        tick();
        idle();
        total++; if ({bus.out0_prs1, bus.out0_prd, bus.out0_old_prd} !== {6'd41, 6'd0, 6'd0})
            $display("FAIL same_reader got %0d/%0d/%0d exp 41/0/0", bus.out0_prs1, bus.out0_prd, bus.out0_old_prd); else passed++;
        tick();
    endtask

    task automatic test_slot1_only();
        bus.in_valid = 1'b1;
        set_slot(0, 1, 4, 0, 9, 0);
        set_slot(1, 1, 1, 9, 10, 1);
        bus.fl_rd_data0 = 6'd50; bus.fl_rd_data1 = 6'd51;
        #1;
        total++; if ({bus.fl_rd_en0, bus.fl_rd_en1} !== 2'b10) $display("FAIL s1only_pops got %b exp 10", {bus.fl_rd_en0, bus.fl_rd_en1}); else passed++;
        tick();
        idle();
        total++; if ({bus.out0_prs1, bus.out0_prd, bus.out0_old_prd} !== {6'd33, 6'd0, 6'd0})
            $display("FAIL s1only_out0 got %0d/%0d/%0d exp 33/0/0", bus.out0_prs1, bus.out0_prd, bus.out0_old_prd); else passed++;
        total++; if ({bus.out1_prs1, bus.out1_prs2, bus.out1_prd, bus.out1_old_prd} !== {6'd32, 6'd9, 6'd50, 6'd10})
            $display("FAIL s1only_out1 got %0d/%0d/%0d/%0d exp 32/9/50/10", bus.out1_prs1, bus.out1_prs2, bus.out1_prd, bus.out1_old_prd); else passed++;
        tick();
    endtask

    task automatic test_freelist_stall();
        bus.in_valid = 1'b1;
        set_slot(0, 1, 0, 0, 11, 1);
        set_slot(1, 1, 0, 0, 12, 1);
        bus.fl_free_cnt = 7'd1;
        bus.fl_rd_data0 = 6'd60; bus.fl_rd_data1 = 6'd61;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got %0d exp 0", bus.in_ready); else passed++;
        total++; if ({bus.fl_rd_en0, bus.fl_rd_en1} !== 2'b00) $display("FAIL stall_pops got %b exp 00", {bus.fl_rd_en0, bus.fl_rd_en1}); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL stall_out_valid got %0d exp 0", bus.out_valid); else passed++;
        bus.fl_free_cnt = 7'd2;
        #1;
        total++; if ({bus.in_ready, bus.fl_rd_en0, bus.fl_rd_en1} !== 3'b111) $display("FAIL stall_release got %b exp 111", {bus.in_ready, bus.fl_rd_en0, bus.fl_rd_en1}); else passed++;
        tick();
        idle();
        total++; if ({bus.out0_prd, bus.out0_old_prd, bus.out1_prd, bus.out1_old_prd} !== {6'd60, 6'd11, 6'd61, 6'd12})
            $display("FAIL stall_result got %0d/%0d/%0d/%0d exp 60/11/61/12", bus.out0_prd, bus.out0_old_prd, bus.out1_prd, bus.out1_old_prd); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        set_slot(0, 1, 0, 0, 13, 1);
        bus.fl_rd_data0 = 6'd34;
        tick();
        set_slot(0, 1, 13, 0, 14, 1);
        bus.fl_rd_data0 = 6'd35;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %0d exp 0", c, bus.in_ready); else passed++;
            total++; if ({bus.out_valid, bus.out0_prd, bus.out0_old_prd} !== {1'b1, 6'd34, 6'd13})
                $display("FAIL bp_hold cycle %0d got %0d/%0d/%0d exp 1/34/13", c, bus.out_valid, bus.out0_prd, bus.out0_old_prd); else passed++;
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release got %0d exp 1", bus.in_ready); else passed++;
        tick();
        idle();
        total++; if ({bus.out0_prs1, bus.out0_prd, bus.out0_old_prd} !== {6'd34, 6'd35, 6'd14})
            $display("FAIL bp_next got %0d/%0d/%0d exp 34/35/14", bus.out0_prs1, bus.out0_prd, bus.out0_old_prd); else passed++;
        tick();
    endtask

    task automatic test_flush();
        bus.in_valid = 1'b1;
        set_slot(0, 1, 0, 0, 1, 1);
        bus.fl_rd_data0 = 6'd42;
        tick();
        set_slot(0, 1, 0, 0, 2, 1);
        bus.fl_rd_data0 = 6'd43;
        tick();
        idle();
        bus.cmt0_valid = 1'b1; bus.cmt0_lrd = 5'd5; bus.cmt0_prd = 6'd44;
        bus.cmt1_valid = 1'b1; bus.cmt1_lrd = 5'd5; bus.cmt1_prd = 6'd45;
        tick();
        bus.cmt0_valid = 1'b1; bus.cmt0_lrd = 5'd1; bus.cmt0_prd = 6'd42;
        bus.cmt1_valid = 1'b1; bus.cmt1_lrd = 5'd0; bus.cmt1_prd = 6'd63;
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        set_slot(0, 1, 0, 0, 3, 1);
        bus.fl_rd_data0 = 6'd46;
        #1;
        total++; if ({bus.in_ready, bus.fl_rd_en0} !== 2'b00) $display("FAIL flush_block got %b exp 00", {bus.in_ready, bus.fl_rd_en0}); else passed++;
        tick();
        idle();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got %0d exp 0", bus.out_valid); else passed++;
        bus.in_valid = 1'b1;
        set_slot(0, 1, 1, 2, 0, 0);
        set_slot(1, 1, 5, 4, 0, 0);
        tick();
        idle();
        total++; if ({bus.out0_prs1, bus.out0_prs2} !== {6'd42, 6'd2}) $display("FAIL flush_restore0 got %0d/%0d exp 42/2", bus.out0_prs1, bus.out0_prs2); else passed++;
        total++; if ({bus.out1_prs1, bus.out1_prs2} !== {6'd45, 6'd4}) $display("FAIL flush_restore1 got %0d/%0d exp 45/4", bus.out1_prs1, bus.out1_prs2); else passed++;
        tick();
    endtask

    task automatic test_mid_reset();
        bus.in_valid = 1'b1;
        set_slot(0, 1, 0, 0, 3, 1);
        bus.fl_rd_data0 = 6'd46;
        tick();
        idle();
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #1;
        total++; if ({bus.out_valid, bus.out0_prd} !== {1'b0, 6'd0}) $display("FAIL midrst_out got %0d/%0d exp 0/0", bus.out_valid, bus.out0_prd); else passed++;
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        set_slot(0, 1, 3, 1, 0, 0);
        tick();
        idle();
        total++; if ({bus.out0_prs1, bus.out0_prs2} !== {6'd3, 6'd1}) $display("FAIL midrst_identity got %0d/%0d exp 3/1", bus.out0_prs1, bus.out0_prs2); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_group();
        test_same_lrd();
        test_slot1_only();
        test_freelist_stall();
        test_backpressure();
        test_flush();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
